// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA test-pattern path.
// Holds the default 640x480@60 timing, the pattern IDs selected by the
// switches, and the colour-bar palette as one-bit-per-channel masks.
package vga_pkg;

    // Default timing (25 MHz pixel clock, 800x525 total).
    localparam int unsigned VGA_TOTAL_COLS  = 800;
    localparam int unsigned VGA_TOTAL_ROWS  = 525;
    localparam int unsigned VGA_ACTIVE_COLS = 640;
    localparam int unsigned VGA_ACTIVE_ROWS = 480;
    localparam int unsigned VGA_VIDEO_WIDTH = 3;
    localparam int unsigned VGA_CHECK_SHIFT = 5;

    // Counter and select widths.
    localparam int unsigned VGA_CNT_W   = 10;
    localparam int unsigned PAT_W       = 3;
    localparam int unsigned NUM_BARS    = 8;
    localparam int unsigned BAR_IDX_W   = 3;
    localparam int unsigned BORDER_PX   = 2;

    typedef logic [PAT_W-1:0] pattern_t;

    // Pattern IDs driven from the switches.
    localparam pattern_t PAT_BLACK   = 3'd0;
    localparam pattern_t PAT_RED     = 3'd1;
    localparam pattern_t PAT_GREEN   = 3'd2;
    localparam pattern_t PAT_BLUE    = 3'd3;
    localparam pattern_t PAT_CHECKER = 3'd4;
    localparam pattern_t PAT_BARS    = 3'd5;
    localparam pattern_t PAT_BORDER  = 3'd6;
    localparam pattern_t PAT_BLACK2  = 3'd7;

    // A colour as full-scale-or-off per channel.
    typedef struct packed {
        logic red;
        logic grn;
        logic blu;
    } rgb_mask_t;

    localparam rgb_mask_t RGB_BLACK   = '{red: 1'b0, grn: 1'b0, blu: 1'b0};
    localparam rgb_mask_t RGB_WHITE   = '{red: 1'b1, grn: 1'b1, blu: 1'b1};
    localparam rgb_mask_t RGB_YELLOW  = '{red: 1'b1, grn: 1'b1, blu: 1'b0};
    localparam rgb_mask_t RGB_CYAN    = '{red: 1'b0, grn: 1'b1, blu: 1'b1};
    localparam rgb_mask_t RGB_GREEN   = '{red: 1'b0, grn: 1'b1, blu: 1'b0};
    localparam rgb_mask_t RGB_MAGENTA = '{red: 1'b1, grn: 1'b0, blu: 1'b1};
    localparam rgb_mask_t RGB_RED     = '{red: 1'b1, grn: 1'b0, blu: 1'b0};
    localparam rgb_mask_t RGB_BLUE    = '{red: 1'b0, grn: 1'b0, blu: 1'b1};

    // Bar palette, left to right across the active line.
    function automatic rgb_mask_t bar_color(input logic [BAR_IDX_W-1:0] idx);
        rgb_mask_t c;
        c = RGB_BLACK;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pin-level bundle between the sync stage / board pins and vga_pattern_gen.
//   i_HSync, i_VSync : active-area sync pulses from the upstream stage
//   i_Pattern        : pattern select from the switches
//   o_HSync, o_VSync : syncs re-aligned to the video (2 CLK late)
//   o_Red/Grn/Blu    : pixel colour
//   o_Col, o_Row     : position of the pixel on the outputs
//   o_Locked         : a frame start has been seen since reset
// master = stimulus/source side, slave = vga_pattern_gen.
interface vga_pattern_gen_if #(
    parameter int unsigned VIDEO_WIDTH = vga_pkg::VGA_VIDEO_WIDTH,
    parameter int unsigned CNT_W       = vga_pkg::VGA_CNT_W
);
    logic                       i_HSync;
    logic                       i_VSync;
    logic [vga_pkg::PAT_W-1:0]  i_Pattern;
    logic                       o_HSync;
    logic                       o_VSync;
    logic [VIDEO_WIDTH-1:0]     o_Red;
    logic [VIDEO_WIDTH-1:0]     o_Grn;
    logic [VIDEO_WIDTH-1:0]     o_Blu;
    logic [CNT_W-1:0]           o_Col;
    logic [CNT_W-1:0]           o_Row;
    logic                       o_Locked;

    modport master (
        output i_HSync, i_VSync, i_Pattern,
        input  o_HSync, o_VSync, o_Red, o_Grn, o_Blu, o_Col, o_Row, o_Locked
    );

    modport slave (
        input  i_HSync, i_VSync, i_Pattern,
        output o_HSync, o_VSync, o_Red, o_Grn, o_Blu, o_Col, o_Row, o_Locked
    );
endinterface

// File: rtl/vga_sync_to_count.sv
// Rebuilds column/row counters from raw active-area sync pulses.
// Ports:
//   CLK, RST          : pixel clock, synchronous active-high reset
//   i_HSync, i_VSync  : raw syncs (high inside the active area)
//   s_HS, s_VS        : syncs registered once (stage S)
//   col_c, row_c      : position of the stage-S pixel
//   fs_c              : stage-S pixel is the first of a frame
//   locked_c          : a frame start has been seen (including this one)
module vga_sync_to_count #(
    parameter int unsigned TOTAL_COLS = vga_pkg::VGA_TOTAL_COLS,
    parameter int unsigned TOTAL_ROWS = vga_pkg::VGA_TOTAL_ROWS,
    parameter int unsigned CNT_W      = vga_pkg::VGA_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_HSync,
    input  logic             i_VSync,
    output logic             s_HS,
    output logic             s_VS,
    output logic [CNT_W-1:0] col_c,
    output logic [CNT_W-1:0] row_c,
    output logic             fs_c,
    output logic             locked_c
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);

    logic             p_HS;
    logic             p_VS;
    logic             locked_q;
    logic [CNT_W-1:0] col_q;
    logic [CNT_W-1:0] row_q;
    logic [CNT_W-1:0] col_nxt;
    logic [CNT_W-1:0] row_nxt;

    // Sync history, free-running position and sticky lock.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s_HS     <= 1'b0;
            s_VS     <= 1'b0;
            p_HS     <= 1'b0;
            p_VS     <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            s_HS     <= i_HSync;
            s_VS     <= i_VSync;
            p_HS     <= s_HS;
            p_VS     <= s_VS;
            col_q    <= col_nxt;
            row_q    <= row_nxt;
            locked_q <= locked_c;
        end
    end

    // A joint rising edge of both syncs overrides the free-running count,
    // so a drifted counter snaps back on exactly that pixel.
    always_comb begin
        fs_c     = s_HS & ~p_HS & s_VS & ~p_VS;
        col_c    = col_q;
        row_c    = row_q;
        if (fs_c) begin
            col_c = '0;
            row_c = '0;
        end
        locked_c = locked_q | fs_c;

        col_nxt  = col_c + CNT_W'(1);
        row_nxt  = row_c;
        if (col_c == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row_c == ROW_LAST) ? '0 : row_c + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Switch-selected VGA test pattern generator locked to upstream syncs.
// Ports:
//   CLK  : 25 MHz pixel clock
//   RST  : synchronous active-high reset
//   vga  : slave side of vga_pattern_gen_if (syncs and pattern in;
//          re-aligned syncs, RGB, position and lock out)
// Latency from any i_* to the matching o_* is two CLK: one in the
// counter stage, one in the output register.
module vga_pattern_gen #(
    parameter int unsigned TOTAL_COLS  = vga_pkg::VGA_TOTAL_COLS,
    parameter int unsigned TOTAL_ROWS  = vga_pkg::VGA_TOTAL_ROWS,
    parameter int unsigned ACTIVE_COLS = vga_pkg::VGA_ACTIVE_COLS,
    parameter int unsigned ACTIVE_ROWS = vga_pkg::VGA_ACTIVE_ROWS,
    parameter int unsigned VIDEO_WIDTH = vga_pkg::VGA_VIDEO_WIDTH,
    parameter int unsigned CHECK_SHIFT = vga_pkg::VGA_CHECK_SHIFT
) (
    input  logic              CLK,
    input  logic              RST,
    vga_pattern_gen_if.slave  vga
);
    import vga_pkg::*;

    localparam int unsigned      CNT_W  = VGA_CNT_W;
    localparam int unsigned      BAR_W  = ACTIVE_COLS / NUM_BARS;
    localparam logic [CNT_W-1:0] EDGE_W = CNT_W'(BORDER_PX);
    localparam logic [CNT_W-1:0] COL_HI = CNT_W'(ACTIVE_COLS - BORDER_PX);
    localparam logic [CNT_W-1:0] ROW_HI = CNT_W'(ACTIVE_ROWS - BORDER_PX);

    logic                 s_HS;
    logic                 s_VS;
    logic [CNT_W-1:0]     col_c;
    logic [CNT_W-1:0]     row_c;
    logic                 fs_c;
    logic                 locked_c;

    pattern_t             pat_q;
    pattern_t             pat_c;
    logic [BAR_IDX_W-1:0] bar_idx_c;
    logic                 checker_c;
    logic                 border_c;
    rgb_mask_t            mask_c;

    vga_sync_to_count #(
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS),
        .CNT_W      (CNT_W)
    ) u_sync_to_count (
        .CLK      (CLK),
        .RST      (RST),
        .i_HSync  (vga.i_HSync),
        .i_VSync  (vga.i_VSync),
        .s_HS     (s_HS),
        .s_VS     (s_VS),
        .col_c    (col_c),
        .row_c    (row_c),
        .fs_c     (fs_c),
        .locked_c (locked_c)
    );

    // Pattern mux for the stage-S pixel.
    always_comb begin
        // New switch setting applies from the first pixel of a frame only.
        pat_c = pat_q;
        if (fs_c) begin
            pat_c = vga.i_Pattern;
        end

        // Bar index by threshold comparison; the last passed threshold wins.
        bar_idx_c = '0;
        for (int unsigned k = 1; k < NUM_BARS; k++) begin
            if (col_c >= CNT_W'(k * BAR_W)) begin
                bar_idx_c = BAR_IDX_W'(k);
            end
        end

        checker_c = col_c[CHECK_SHIFT] ^ row_c[CHECK_SHIFT];
        border_c  = (col_c < EDGE_W) || (col_c >= COL_HI) ||
                    (row_c < EDGE_W) || (row_c >= ROW_HI);

        mask_c = RGB_BLACK;
        case (pat_c)
            PAT_RED:     mask_c = RGB_RED;
            PAT_GREEN:   mask_c = RGB_GREEN;
            PAT_BLUE:    mask_c = RGB_BLUE;
            PAT_CHECKER: mask_c = checker_c ? RGB_WHITE : RGB_BLACK;
            PAT_BARS:    mask_c = bar_color(bar_idx_c);
            PAT_BORDER:  mask_c = border_c ? RGB_WHITE : RGB_BLACK;
            default:     mask_c = RGB_BLACK;
        endcase

        // Blanking and the pre-lock period are always black.
        if (!(s_HS && s_VS && locked_c)) begin
            mask_c = RGB_BLACK;
        end
    end

    // Output stage O: everything re-timed together so syncs match video.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pat_q        <= PAT_BLACK;
            vga.o_HSync  <= 1'b0;
            vga.o_VSync  <= 1'b0;
            vga.o_Red    <= '0;
            vga.o_Grn    <= '0;
            vga.o_Blu    <= '0;
            vga.o_Col    <= '0;
            vga.o_Row    <= '0;
            vga.o_Locked <= 1'b0;
        end else begin
            pat_q        <= pat_c;
            vga.o_HSync  <= s_HS;
            vga.o_VSync  <= s_VS;
            vga.o_Red    <= {VIDEO_WIDTH{mask_c.red}};
            vga.o_Grn    <= {VIDEO_WIDTH{mask_c.grn}};
            vga.o_Blu    <= {VIDEO_WIDTH{mask_c.blu}};
            vga.o_Col    <= col_c;
            vga.o_Row    <= row_c;
            vga.o_Locked <= locked_c;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: lane 0 is the full 800x525 instance driven by a
// scripted stream, lane 1 a reduced-timing instance driven with random
// pattern changes, idle-cycle injections and resets. Both are compared every
// cycle against a position/pattern model, plus literal spot values.
module tb_vga_pattern_gen;

    localparam int L1_TC = 100;
    localparam int L1_TR = 30;
    localparam int L1_AC = 80;
    localparam int L1_AR = 20;
    localparam int L1_CS = 2;
    localparam int CYCLES = 42000;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
        logic [9:0] col;
        logic [9:0] row;
        logic       lock;
    } obs_t;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    vga_pattern_gen_if #(.VIDEO_WIDTH(3), .CNT_W(10)) if0 ();
    vga_pattern_gen_if #(.VIDEO_WIDTH(3), .CNT_W(10)) if1 ();

    vga_pattern_gen #(
        .TOTAL_COLS(800), .TOTAL_ROWS(525), .ACTIVE_COLS(640),
        .ACTIVE_ROWS(480), .VIDEO_WIDTH(3), .CHECK_SHIFT(5)
    ) dut0 (.CLK(clk), .RST(rst0), .vga(if0));

    vga_pattern_gen #(
        .TOTAL_COLS(L1_TC), .TOTAL_ROWS(L1_TR), .ACTIVE_COLS(L1_AC),
        .ACTIVE_ROWS(L1_AR), .VIDEO_WIDTH(3), .CHECK_SHIFT(L1_CS)
    ) dut1 (.CLK(clk), .RST(rst1), .vga(if1));

    always #20 clk = ~clk;

    int tc [2];
    int tr [2];
    int ac [2];
    int ar [2];
    int cs [2];

    // Stream generator position and pins applied at the coming edge.
    int gcol [2];
    int grow [2];
    bit ain_hs [2];
    bit ain_vs [2];
    bit ain_rst [2];
    int ain_pat [2];
    bit prev_hs [2];
    bit prev_vs [2];
    bit prev_rst [2];

    // Model: sync history, linear pixel position, latched pattern, lock.
    bit   ms_hs [2];
    bit   ms_vs [2];
    bit   mp_hs [2];
    bit   mp_vs [2];
    int   mpos [2];
    int   mpat [2];
    bit   mlock [2];
    obs_t exp_o [2];
    int   exp_pat [2];
    obs_t dut_o [2];

    int n_checks = 0;
    int n_errors = 0;

    int phase0 = 0;
    bit held0 = 1'b0;
    bit lock_seen0 = 1'b0;
    int t_rise0 = -10;
    int rst1_left = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_obs(input int k, input int cyc, input obs_t a, input obs_t e);
        n_checks++;
        if (a != e) begin
            n_errors++;
            $display("FAIL model_lane%0d cyc=%0d: got hs=%0b vs=%0b rgb=%0d,%0d,%0d col=%0d row=%0d lock=%0b expected hs=%0b vs=%0b rgb=%0d,%0d,%0d col=%0d row=%0d lock=%0b",
                     k, cyc, a.hs, a.vs, a.r, a.g, a.b, a.col, a.row, a.lock,
                     e.hs, e.vs, e.r, e.g, e.b, e.col, e.row, e.lock);
        end
    endtask

    function automatic int bar_mask(input int idx);
        case (idx)
            0: return 7;  // white
            1: return 6;  // yellow
            2: return 3;  // cyan
            3: return 2;  // green
            4: return 5;  // magenta
            5: return 4;  // red
            6: return 1;  // blue
            default: return 0;
        endcase
    endfunction

    // Colour mask (bit2=R, bit1=G, bit0=B) from the pattern rules.
    function automatic int exp_mask(input int pat, input int col, input int row,
                                    input int a_c, input int a_r, input int sh,
                                    input bit act, input bit lock);
        if (!(act && lock)) return 0;
        case (pat)
            1: return 4;
            2: return 2;
            3: return 1;
            4: return ((((col >> sh) + (row >> sh)) % 2) == 1) ? 7 : 0;
            5: return bar_mask(col / (a_c / 8));
            6: return (col < 2 || col >= a_c - 2 || row < 2 || row >= a_r - 2) ? 7 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input int k);
        obs_t e;
        bit   fs;
        int   pos;
        int   pat;
        bit   lock;
        int   m;
        e = '0;
        if (ain_rst[k]) begin
            ms_hs[k] = 0; ms_vs[k] = 0; mp_hs[k] = 0; mp_vs[k] = 0;
            mpos[k] = 0; mpat[k] = 0; mlock[k] = 0;
            exp_pat[k] = 0;
        end else begin
            fs   = ms_hs[k] && !mp_hs[k] && ms_vs[k] && !mp_vs[k];
            pos  = fs ? 0 : mpos[k];
            pat  = fs ? ain_pat[k] : mpat[k];
            lock = mlock[k] || fs;
            m    = exp_mask(pat, pos % tc[k], pos / tc[k], ac[k], ar[k], cs[k],
                            ms_hs[k] && ms_vs[k], lock);
            e.hs   = ms_hs[k];
            e.vs   = ms_vs[k];
            e.r    = m[2] ? 3'd7 : 3'd0;
            e.g    = m[1] ? 3'd7 : 3'd0;
            e.b    = m[0] ? 3'd7 : 3'd0;
            e.col  = 10'(pos % tc[k]);
            e.row  = 10'(pos / tc[k]);
            e.lock = lock;
            exp_pat[k] = pat;
            mlock[k] = lock;
            mpat[k]  = pat;
            mpos[k]  = (pos + 1) % (tc[k] * tr[k]);
            mp_hs[k] = ms_hs[k];
            mp_vs[k] = ms_vs[k];
            ms_hs[k] = ain_hs[k];
            ms_vs[k] = ain_vs[k];
        end
        exp_o[k] = e;
    endtask

    task automatic gen_step(input int k, input bit hold);
        ain_hs[k] = gcol[k] < ac[k];
        ain_vs[k] = grow[k] < ar[k];
        if (!hold) begin
            gcol[k]++;
            if (gcol[k] == tc[k]) begin
                gcol[k] = 0;
                grow[k]++;
                if (grow[k] == tr[k]) grow[k] = 0;
            end
        end
    endtask

    task automatic drive_pins();
        rst0 = ain_rst[0];
        rst1 = ain_rst[1];
        if0.i_HSync   = ain_hs[0];
        if0.i_VSync   = ain_vs[0];
        if0.i_Pattern = 3'(ain_pat[0]);
        if1.i_HSync   = ain_hs[1];
        if1.i_VSync   = ain_vs[1];
        if1.i_Pattern = 3'(ain_pat[1]);
    endtask

    function automatic int lit_rgb(input obs_t o);
        return {23'd0, o.r, o.g, o.b};
    endfunction

    initial begin
        tc[0] = 800;   tr[0] = 525;   ac[0] = 640;   ar[0] = 480;   cs[0] = 5;
        tc[1] = L1_TC; tr[1] = L1_TR; ac[1] = L1_AC; ar[1] = L1_AR; cs[1] = L1_CS;
        gcol[0] = 0; grow[0] = 522;
        gcol[1] = 0; grow[1] = L1_TR - 1;
        ain_pat[0] = 1;
        ain_pat[1] = int'($urandom_range(0, 7));
        for (int k = 0; k < 2; k++) begin
            ain_rst[k] = 1'b1;
            prev_hs[k] = 1'b0; prev_vs[k] = 1'b0; prev_rst[k] = 1'b1;
            gen_step(k, 1'b0);
        end
        drive_pins();

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            model_step(0);
            model_step(1);
            dut_o[0] = {if0.o_HSync, if0.o_VSync, if0.o_Red, if0.o_Grn, if0.o_Blu,
                        if0.o_Col, if0.o_Row, if0.o_Locked};
            dut_o[1] = {if1.o_HSync, if1.o_VSync, if1.o_Red, if1.o_Grn, if1.o_Blu,
                        if1.o_Col, if1.o_Row, if1.o_Locked};
            chk_obs(0, cyc, dut_o[0], exp_o[0]);
            chk_obs(1, cyc, dut_o[1], exp_o[1]);

            // Reset: all outputs zero right after the first reset edge.
            for (int k = 0; k < 2; k++) begin
                if (ain_rst[k] && (!prev_rst[k] || cyc == 0))
                    chk($sformatf("reset_zero_lane%0d", k), int'(dut_o[k]), 0);
            end

            // Lock latency: first lock two CLK after the joint sync rise.
            if (!lock_seen0 && dut_o[0].lock) begin
                lock_seen0 = 1'b1;
                chk("lock_latency", cyc, t_rise0 + 1);
                chk("lock_col", int'(dut_o[0].col), 0);
                chk("lock_row", int'(dut_o[0].row), 0);
                chk("lock_red", int'(dut_o[0].r), 7);
            end
            if (!ain_rst[0] && !prev_rst[0] && ain_hs[0] && ain_vs[0] &&
                !prev_hs[0] && !prev_vs[0] && t_rise0 < 0)
                t_rise0 = cyc;

            // HSync re-emitted exactly two CLK after it was applied.
            if (cyc >= 1 && !ain_rst[0] && !prev_rst[0])
                chk("hsync_delay2", int'(dut_o[0].hs), int'(prev_hs[0]));

            // Colour bar boundaries (rgb packed as R*64+G*8+B).
            if (exp_pat[0] == 5 && exp_o[0].lock && exp_o[0].row == 10'd1) begin
                case (int'(exp_o[0].col))
                    79:  chk("bar_col79",  lit_rgb(dut_o[0]), 'o777);
                    80:  chk("bar_col80",  lit_rgb(dut_o[0]), 'o770);
                    479: chk("bar_col479", lit_rgb(dut_o[0]), 'o700);
                    480: chk("bar_col480", lit_rgb(dut_o[0]), 'o007);
                    639: chk("bar_col639", lit_rgb(dut_o[0]), 'o000);
                    640: chk("bar_col640", lit_rgb(dut_o[0]), 'o000);
                    default: ;
                endcase
            end
            if (exp_pat[0] == 5 && exp_o[0].lock && exp_o[0].row == 10'd2 &&
                exp_o[0].col == 10'd0) begin
                chk("wrap_col", int'(dut_o[0].col), 0);
                chk("wrap_row", int'(dut_o[0].row), 2);
            end

            // Checkerboard after resync: squares are 32 px.
            if (exp_pat[0] == 4 && exp_o[0].lock && exp_o[0].row == 10'd0) begin
                case (int'(exp_o[0].col))
                    31: chk("chk_col31", lit_rgb(dut_o[0]), 'o000);
                    32: chk("chk_col32", lit_rgb(dut_o[0]), 'o777);
                    63: chk("chk_col63", lit_rgb(dut_o[0]), 'o777);
                    64: chk("chk_col64", lit_rgb(dut_o[0]), 'o000);
                    default: ;
                endcase
            end
            if (exp_pat[0] == 4 && exp_o[0].lock && exp_o[0].row == 10'd32 &&
                exp_o[0].col == 10'd5)
                chk("chk_row32", lit_rgb(dut_o[0]), 'o777);

            for (int k = 0; k < 2; k++) begin
                prev_hs[k]  = ain_hs[k];
                prev_vs[k]  = ain_vs[k];
                prev_rst[k] = ain_rst[k];
            end

            // Lane 0 script: red frame, bars frame, resync into checkerboard.
            ain_rst[0] = (cyc + 1) < 3;
            if (phase0 == 0 && grow[0] == 3 && gcol[0] == 0) begin
                phase0 = 1; ain_pat[0] = 5; grow[0] = 524;
            end else if (phase0 == 1 && grow[0] == 4 && gcol[0] == 0) begin
                phase0 = 2; ain_pat[0] = 4; grow[0] = 524;
            end else if (phase0 == 2 && grow[0] == 33 && gcol[0] == 0) begin
                phase0 = 3;
            end
            if (phase0 == 2 && grow[0] == 524 && gcol[0] == 400 && !held0) begin
                held0 = 1'b1;
                gen_step(0, 1'b1);
            end else begin
                gen_step(0, 1'b0);
            end

            // Lane 1: random pattern flips, idle cycles and resets.
            if (rst1_left == 0) begin
                if (cyc + 1 == 20000)
                    rst1_left = 3;
                else if (grow[1] >= L1_AR && $urandom_range(0, 1999) == 0)
                    rst1_left = int'($urandom_range(1, 3));
            end
            ain_rst[1] = rst1_left > 0;
            if (rst1_left > 0) rst1_left--;
            if ($urandom_range(0, 399) == 0)
                ain_pat[1] = int'($urandom_range(0, 7));
            gen_step(1, $urandom_range(0, 999) == 0);

            drive_pins();
        end

        chk("lane0_locked_seen", int'(lock_seen0), 1);
        chk("lane0_script_done", phase0, 3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
